idli_sqi_resp_m: RTL and testbench

SQI (quad-SPI) memory responder: the memory-side end of the link driven by the core's SQI controller. Decodes serial-quad READ (0x03) and WRITE (0x02) transactions nibble-by-nibble into an internal byte array and returns read data on the quad bus. Used as a synthesizable external-SRAM stand-in for simulation and FPGA bring-up. Includes a backdoor port for preloading program images while the bus is idle.

---
 rtl/idli_sqi_resp_pkg.sv | 20 ++
 rtl/idli_sqi_resp_mem_m.sv | 24 ++
 rtl/idli_sqi_resp_m.sv | 189 ++++++++++++++++++
 tb/tb_idli_sqi_resp_m.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idli_sqi_resp_pkg.sv
// Shared types and constants for the SQI memory responder.
// Command codes and phase lengths used by the responder FSM.
package idli_sqi_resp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_SKIP
    } resp_st_t;

    localparam logic [7:0] SQI_CMD_READ   = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE  = 8'h02;
    localparam logic [2:0] SQI_DUMMY_NIBS = 3'd2;
    localparam logic [2:0] SQI_ADDR_NIBS  = 3'd6;

endpackage

// File: rtl/idli_sqi_resp_mem_m.sv
// Byte array behind the SQI responder.
// One synchronous write port, one combinational read port.
module idli_sqi_resp_mem_m #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/idli_sqi_resp_m.sv
// SQI memory responder: decodes quad READ/WRITE into a byte array.
// Backdoor preload port is only served while the bus is idle.
module idli_sqi_resp_m
    import idli_sqi_resp_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              i_resp_gck,
    input  logic              i_resp_rst,
    input  logic              i_resp_sqi_sck,
    input  logic              i_resp_sqi_cs,
    input  logic [3:0]        i_resp_sqi_data,
    output logic [3:0]        o_resp_sqi_data,
    output logic              o_resp_sqi_oe,
    input  logic              i_resp_bd_vld,
    input  logic [ADDR_W-1:0] i_resp_bd_addr,
    input  logic [7:0]        i_resp_bd_data,
    output logic              o_resp_bd_acp,
    output logic              o_resp_err
);

    resp_st_t          st_q, st_d;
    logic              sck_q;
    logic [2:0]        cnt_q, cnt_d;
    logic              half_q, half_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        hi_q, hi_d;
    logic              is_rd_q, is_rd_d;
    logic [3:0]        dout_q, dout_d;
    logic              oe_q, oe_d;
    logic              err_q, err_d;
    logic              armed_q, armed_d;

    logic              rise, fall, idle;
    logic [7:0]        cmd;
    logic              bus_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic [7:0]        rd_byte;

    assign rise = i_resp_sqi_sck & ~sck_q;
    assign fall = ~i_resp_sqi_sck & sck_q;
    assign idle = (st_q == ST_IDLE);
    assign cmd  = {hi_q, i_resp_sqi_data};

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        addr_d  = addr_q;
        hi_d    = hi_q;
        is_rd_d = is_rd_q;
        dout_d  = dout_q;
        oe_d    = oe_q;
        err_d   = err_q;
        armed_d = armed_q;
        bus_we  = 1'b0;
        if (i_resp_sqi_cs) begin
            st_d    = ST_IDLE;
            cnt_d   = 3'd0;
            half_d  = 1'b0;
            oe_d    = 1'b0;
            armed_d = 1'b1;
        end else begin
            unique case (st_q)
                // armed_q stays low after reset until cs is seen high
                ST_IDLE: begin
                    if (armed_q) begin
                        st_d  = ST_CMD;
                        cnt_d = 3'd0;
                    end
                end
                ST_CMD: begin
                    if (rise) begin
                        hi_d  = i_resp_sqi_data;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd1) begin
                            cnt_d = 3'd0;
                            if (cmd == SQI_CMD_READ || cmd == SQI_CMD_WRITE) begin
                                st_d    = ST_ADDR;
                                is_rd_d = (cmd == SQI_CMD_READ);
                            end else begin
                                st_d  = ST_SKIP;
                                err_d = 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        addr_d = ADDR_W'({addr_q, i_resp_sqi_data});
                        cnt_d  = cnt_q + 3'd1;
                        if (cnt_q == SQI_ADDR_NIBS - 3'd1) begin
                            cnt_d  = 3'd0;
                            half_d = 1'b0;
                            st_d   = is_rd_q ? ST_DUMMY : ST_WDATA;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (rise) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == SQI_DUMMY_NIBS - 3'd1) begin
                            cnt_d = 3'd0;
                            st_d  = ST_RDATA;
                            oe_d  = 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (rise) begin
                        half_d = ~half_q;
                        if (half_q) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end else if (fall) begin
                        dout_d = half_q ? rd_byte[3:0] : rd_byte[7:4];
                    end
                end
                ST_WDATA: begin
                    if (rise) begin
                        if (!half_q) begin
                            hi_d   = i_resp_sqi_data;
                            half_d = 1'b1;
                        end else begin
                            bus_we = 1'b1;
                            half_d = 1'b0;
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_SKIP: begin
                end
                default: st_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_resp_gck) begin
        if (i_resp_rst) begin
            st_q    <= ST_IDLE;
            sck_q   <= 1'b0;
            cnt_q   <= 3'd0;
            half_q  <= 1'b0;
            addr_q  <= '0;
            hi_q    <= 4'd0;
            is_rd_q <= 1'b0;
            dout_q  <= 4'd0;
            oe_q    <= 1'b0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            sck_q   <= i_resp_sqi_sck;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            is_rd_q <= is_rd_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            err_q   <= err_d;
            armed_q <= armed_d;
        end
    end

    // Backdoor owns the write port while idle, the bus otherwise
    assign o_resp_bd_acp = i_resp_bd_vld & i_resp_sqi_cs & idle & ~i_resp_rst;
    assign mem_we    = ~i_resp_rst & (idle ? o_resp_bd_acp : bus_we);
    assign mem_waddr = idle ? i_resp_bd_addr : addr_q;
    assign mem_wdata = idle ? i_resp_bd_data : {hi_q, i_resp_sqi_data};

    idli_sqi_resp_mem_m #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (i_resp_gck),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (addr_q),
        .rdata_o (rd_byte)
    );

    assign o_resp_sqi_data = dout_q;
    assign o_resp_sqi_oe   = oe_q;
    assign o_resp_err      = err_q;

endmodule

// File: tb/tb_idli_sqi_resp_m.sv
// Bench for idli_sqi_resp_m: table vectors, corner sequences, random
// transactions against a byte-array memory model.
module tb_idli_sqi_resp_m;

    logic       gck = 1'b0;
    logic       rst;
    logic       sck;
    logic       cs;
    logic [3:0] sdi;
    logic [3:0] sdo;
    logic       oe;
    logic       bd_vld;
    logic [7:0] bd_addr;
    logic [7:0] bd_data;
    logic       acp;
    logic       err;

    idli_sqi_resp_m #(.ADDR_W(8)) dut (
        .i_resp_gck      (gck),
        .i_resp_rst      (rst),
        .i_resp_sqi_sck  (sck),
        .i_resp_sqi_cs   (cs),
        .i_resp_sqi_data (sdi),
        .o_resp_sqi_data (sdo),
        .o_resp_sqi_oe   (oe),
        .i_resp_bd_vld   (bd_vld),
        .i_resp_bd_addr  (bd_addr),
        .i_resp_bd_data  (bd_data),
        .o_resp_bd_acp   (acp),
        .o_resp_err      (err)
    );

    always #5 gck = ~gck;

    typedef struct packed {
        logic        wr;
        logic [23:0] a;
        logic [2:0]  n;
        logic [31:0] d;
    } vec_t;

    vec_t       tbl [7];
    logic [7:0] mdl [256];
    logic [7:0] rbuf [4];
    logic [3:0] last_q;
    logic       last_oe;
    logic       exp_oe;
    logic       mon_en = 1'b0;
    int         oe_bad;
    int         acp_bad;
    int         checks = 0;
    int         failures = 0;

    always begin
        @(negedge gck);
        #2;
        if (mon_en && acp) acp_bad++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Sample what the previous fall produced, then one rise/fall pair.
    task automatic nib(input logic [3:0] d);
        @(negedge gck);
        last_q  = sdo;
        last_oe = oe;
        if (last_oe !== exp_oe) oe_bad++;
        sck = 1'b1;
        sdi = d;
        @(negedge gck);
        @(negedge gck);
        sck = 1'b0;
        @(negedge gck);
    endtask

    task automatic cs_lo();
        @(negedge gck);
        cs = 1'b0;
        @(negedge gck);
    endtask

    task automatic cs_hi();
        @(negedge gck);
        cs = 1'b1;
        @(negedge gck);
        @(negedge gck);
        if (oe !== 1'b0) oe_bad++;
    endtask

    task automatic hdr(input logic [7:0] c, input logic [23:0] a);
        nib(c[7:4]);
        nib(c[3:0]);
        for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4]);
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        logic [3:0] h;
        exp_oe = 1'b0;
        oe_bad = 0;
        cs_lo();
        hdr(8'h03, a);
        nib(4'h0);
        nib(4'h0);
        exp_oe = 1'b1;
        for (int k = 0; k < n; k++) begin
            nib(4'h0);
            h = last_q;
            nib(4'h0);
            rbuf[k] = {h, last_q};
        end
        exp_oe = 1'b0;
        cs_hi();
    endtask

    task automatic do_write(input logic [23:0] a, input int n, input logic [31:0] d);
        exp_oe = 1'b0;
        oe_bad = 0;
        cs_lo();
        hdr(8'h02, a);
        for (int k = 0; k < n; k++) begin
            nib(d[31-8*k -: 4]);
            nib(d[27-8*k -: 4]);
            mdl[8'(a + 24'(k))] = d[31-8*k -: 8];
        end
        cs_hi();
    endtask

    task automatic read_vs_model(input string nm, input logic [23:0] a, input int n);
        do_read(a, n);
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_b%0d", nm, k), rbuf[k], mdl[8'(a + 24'(k))]);
        chk({nm, "_oe"}, oe_bad, 0);
    endtask

    initial begin
        logic [7:0]  b;
        logic [23:0] ra;
        int          acc;
        int          w;
        int          rn;

        tbl[0] = '{1'b0, 24'h000010, 3'd2, 32'hA53C_0000};
        tbl[1] = '{1'b1, 24'h0000FE, 3'd3, 32'h1122_3300};
        tbl[2] = '{1'b0, 24'h0000FE, 3'd3, 32'h1122_3300};
        tbl[3] = '{1'b0, 24'h5A00FF, 3'd2, 32'h2233_0000};
        tbl[4] = '{1'b0, 24'h000000, 3'd1, 32'h3300_0000};
        tbl[5] = '{1'b1, 24'h000011, 3'd1, 32'h5D00_0000};
        tbl[6] = '{1'b0, 24'hFFFF10, 3'd2, 32'hA55D_0000};

        rst = 1'b1;
        cs = 1'b1;
        sck = 1'b0;
        sdi = 4'h0;
        bd_vld = 1'b0;
        bd_addr = 8'h0;
        bd_data = 8'h0;
        exp_oe = 1'b0;
        repeat (3) @(negedge gck);
        bd_vld = 1'b1;
        #1;
        chk("rst_acp", acp, 0);
        chk("rst_oe", oe, 0);
        chk("rst_sdo", sdo, 0);
        chk("rst_err", err, 0);
        bd_vld = 1'b0;
        rst = 1'b0;

        // Preload the whole array, one backdoor write per cycle.
        acc = 0;
        @(negedge gck);
        for (int i = 0; i < 256; i++) begin
            if (i == 16) b = 8'hA5;
            else if (i == 17) b = 8'h3C;
            else if (i == 33) b = 8'h4B;
            else b = 8'($urandom);
            mdl[i] = b;
            bd_vld = 1'b1;
            bd_addr = 8'(i);
            bd_data = b;
            #1;
            if (acp) acc++;
            @(negedge gck);
        end
        bd_vld = 1'b0;
        chk("bd_stream_acp", acc, 256);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].a, int'(tbl[i].n), tbl[i].d);
            end else begin
                do_read(tbl[i].a, int'(tbl[i].n));
                for (int k = 0; k < int'(tbl[i].n); k++)
                    chk($sformatf("tbl%0d_b%0d", i, k), rbuf[k], tbl[i].d[31-8*k -: 8]);
                chk($sformatf("tbl%0d_oe", i), oe_bad, 0);
            end
        end

        // Lone high nibble after a full byte must be dropped.
        exp_oe = 1'b0;
        cs_lo();
        hdr(8'h02, 24'h000020);
        nib(4'h7);
        nib(4'hE);
        nib(4'h9);
        cs_hi();
        mdl[8'h20] = 8'h7E;
        do_read(24'h000020, 2);
        chk("partial_b0", rbuf[0], 8'h7E);
        chk("partial_b1", rbuf[1], 8'h4B);

        // Unsupported command, followed by nibbles shaped like a write.
        exp_oe = 1'b0;
        oe_bad = 0;
        cs_lo();
        nib(4'h0);
        nib(4'h5);
        chk("badcmd_err", err, 1);
        for (int i = 0; i < 6; i++) nib(i == 4 ? 4'h1 : 4'h0);
        nib(4'hF);
        nib(4'hF);
        cs_hi();
        chk("badcmd_oe", oe_bad, 0);
        chk("badcmd_sticky", err, 1);
        read_vs_model("after_bad", 24'h000010, 2);
        chk("err_still", err, 1);

        // Backdoor request held across a bus transaction.
        exp_oe = 1'b0;
        oe_bad = 0;
        cs_lo();
        bd_vld = 1'b1;
        bd_addr = 8'h41;
        bd_data = 8'h99;
        acp_bad = 0;
        mon_en = 1'b1;
        hdr(8'h03, 24'h000040);
        nib(4'h0);
        nib(4'h0);
        exp_oe = 1'b1;
        nib(4'h0);
        nib(4'h0);
        mon_en = 1'b0;
        exp_oe = 1'b0;
        chk("acp_busy", acp_bad, 0);
        @(negedge gck);
        cs = 1'b1;
        #1;
        chk("acp_cs_edge", acp, 0);
        w = 0;
        while (!acp && w < 10) begin
            @(negedge gck);
            #1;
            w++;
        end
        chk("acp_first_idle", w, 1);
        @(negedge gck);
        bd_vld = 1'b0;
        mdl[8'h41] = 8'h99;
        @(negedge gck);
        read_vs_model("bd_landed", 24'h000040, 2);

        // Reset in the middle of a read, transaction left in flight.
        exp_oe = 1'b0;
        oe_bad = 0;
        cs_lo();
        hdr(8'h03, 24'h000010);
        nib(4'h0);
        nib(4'h0);
        exp_oe = 1'b1;
        nib(4'h0);
        nib(4'h0);
        @(negedge gck);
        rst = 1'b1;
        cs = 1'b1;
        bd_vld = 1'b1;
        bd_addr = 8'h55;
        bd_data = 8'h00;
        #1;
        chk("acp_in_rst", acp, 0);
        @(negedge gck);
        chk("midrst_oe", oe, 0);
        chk("midrst_sdo", sdo, 0);
        chk("midrst_err", err, 0);
        bd_vld = 1'b0;
        cs = 1'b0;
        @(negedge gck);
        rst = 1'b0;
        exp_oe = 1'b0;
        oe_bad = 0;
        hdr(8'h02, 24'h000010);
        nib(4'hF);
        nib(4'hF);
        nib(4'hF);
        nib(4'hF);
        chk("inflight_oe", oe_bad, 0);
        chk("inflight_err", err, 0);
        cs_hi();
        read_vs_model("post_rst", 24'h000010, 2);

        // Random transactions against the model.
        for (int t = 0; t < 40; t++) begin
            ra = 24'($urandom);
            rn = int'($urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) begin
                do_write(ra, rn, $urandom);
                chk($sformatf("rnd%0d_wr_oe", t), oe_bad, 0);
            end else begin
                read_vs_model($sformatf("rnd%0d", t), ra, rn);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
